angle_setpoint_mapper: RTL and testbench
========================================

Name: angle_setpoint_mapper

Overview:
Parametrised, multi-channel successor to the angle-to-rate stage in the flight-control pipeline. It sits between the receiver decode and the body-rate PID.
- Each of N_CH axis channels maps an 8-bit stick value to a signed Q12.4 setpoint.
- Channels flagged for angle mode subtract (or add, per channel) the IMU angle, then apply deadband, gain shift and saturation.
- Channels are processed serially through one shared datapath. Outputs commit atomically, with a start/active/complete handshake.

Parameters:
N_CH, 3, number of axis channels (index 0 yaw, 1 pitch, 2 roll)
REC_W, 8, receiver value width
RATE_W, 16, output width, signed Q(RATE_W-4).4
CENTER, 500, stick centre after {rec,2'b00} mapping (31.25)
ACT_INVERT, 3'b100, per-channel bit: 1 = add actual instead of subtract
DEADBAND, 8, |error| <= DEADBAND forces error to 0 (0.5 deg)
GAIN_SHIFT, 0, arithmetic left shift applied after deadband
LIMIT, 1600, symmetric rate clamp ±LIMIT (100.0)
THR_MAX, 4000, throttle upper clamp (250.0)

Ports:
us_clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
start_signal  in  1  request; rising edge triggers one computation
mode_angle  in  N_CH  per-channel: 1 = angle mode (use actual), 0 = rate mode
throttle_target  in  REC_W  unsigned stick value
targets  in  N_CH*REC_W  packed stick values, channel i at [i*REC_W +: REC_W]
actuals  in  N_CH*RATE_W  packed signed IMU angles, Q12.4
throttle_rate_out  out  RATE_W  clamped throttle
rate_out  out  N_CH*RATE_W  packed clamped rate setpoints
angle_error  out  N_CH*RATE_W  packed post-deadband error, saturated to RATE_W
sat_flags  out  N_CH  channel i clamped on last run
active_signal  out  1  high in LATCH and CALC
complete_signal  out  1  one-cycle pulse in DONE

Behaviour:
- Reset: all outputs 0, state IDLE, pending 0, start edge-detect register 0.
- Start detection: start_rise = start_signal & ~start_q. A held-high start triggers once only.
- States: IDLE, LATCH, CALC, DONE.
  - IDLE: on start_rise -> LATCH.
  - LATCH (1 cycle): captures throttle_target, targets, actuals, mode_angle; ch_idx=0; -> CALC.
  - CALC (N_CH cycles): processes channel ch_idx, writes result to shadow registers. Increments ch_idx; when ch_idx==N_CH-1, -> DONE.
  - DONE (1 cycle): complete_signal=1. If pending, -> LATCH and clear pending; else -> IDLE.
- Output commit: rate_out, angle_error, sat_flags and throttle_rate_out load from shadow on the edge entering DONE. They hold otherwise.
- Latency: start edge sampled at edge t0 -> complete high during cycle t0+N_CH+1 (4 cycles for N_CH=3). New outputs are visible in that same cycle.
- start_rise in LATCH, CALC or DONE sets pending (one-deep; further edges merge). Inputs are re-latched for the rerun.
- start_rise in IDLE is coincident with no other event; go to LATCH, pending unchanged.
- Per-channel arithmetic, signed, RATE_W+3 bits internal:
  - mapped = {rec,2'b00} zero-extended - CENTER; range -500..520.
  - err = mapped; if mode_angle: err = mapped + actual when ACT_INVERT[i], else mapped - actual.
  - If |err| <= DEADBAND: err = 0.
  - scaled = err <<< GAIN_SHIFT.
  - If scaled > LIMIT: out = LIMIT, sat=1. If scaled < -LIMIT: out = -LIMIT, sat=1. Otherwise out = scaled, sat=0.
  - angle_error = err saturated to RATE_W signed range.
- Throttle, computed in LATCH into shadow: {rec, 4'b0000} zero-extended; clamp to THR_MAX. There is no lower clamp (value is always >= 0).
- Reset mid-operation: immediate return to IDLE. Outputs zeroed, pending lost, no complete pulse.
- Outputs never take partial (mid-CALC) values.

Decomposition:
- Shared defines file (common_defines.v): RATE_BIT_WIDTH, REC_VAL_BIT_WIDTH, channel index constants (CH_YAW=0, CH_PITCH=1, CH_ROLL=2), Q12.4 constants (LIMIT_100=1600, THR_250=4000, CENTER_31P25=500).
- State encodings: local one-hot localparams.
- One natural sub-module: sat_clamp. Parameterised input width, output width and limit; combinational signed clamp producing value and sat flag. Used for the rate clamp and the angle_error saturation.

Test Plan:
- Defaults, all mode_angle=0; yaw rec=200, pitch rec=125, roll rec=50; start pulse -> after 4 cycles complete=1 for one cycle; yaw=300, pitch=0, roll=-300, sat_flags=000.
- mode_angle=110, pitch rec=125, actual=0x00A0; roll rec=125, actual=0x00A0 -> pitch=-160 (0xFF60), roll=+160 (0x00A0), angle_error matches.
- Pitch angle mode, rec=250, actual=-1600 -> err=2100, rate_out=1600, sat_flags[1]=1, angle_error=2100. Roll rec=0, rate mode -> -500, no sat.
- Deadband: pitch angle mode, rec=125, actual=5 -> rate 0; actual=9 -> rate -9.
- Throttle rec=250 -> 4000; THR_MAX=3200 build, rec=250 -> 3200; rec=0 -> 0.
- Start held high 20 cycles -> exactly one complete. Second rising edge during CALC -> second run back-to-back (DONE -> LATCH). resetn low in CALC -> outputs 0, no complete.

Source files
------------

// File: rtl/angle_setpoint_mapper_pkg.sv
// Shared widths, Q12.4 constants and FSM encoding for the angle-to-rate setpoint mapper.
package angle_setpoint_mapper_pkg;

  localparam int RATE_BIT_WIDTH    = 16;
  localparam int REC_VAL_BIT_WIDTH = 8;
  localparam int N_CH_DEF          = 3;

  localparam int CH_YAW   = 0;
  localparam int CH_PITCH = 1;
  localparam int CH_ROLL  = 2;

  localparam int LIMIT_100     = 1600;
  localparam int THR_250       = 4000;
  localparam int CENTER_31P25  = 500;
  localparam int DEADBAND_0P5  = 8;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_LATCH = 4'b0010,
    ST_CALC  = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

endpackage

// File: rtl/angle_setpoint_mapper_if.sv
// Start/complete handshake plus stick, IMU and setpoint buses of the mapper.
interface angle_setpoint_mapper_if
  import angle_setpoint_mapper_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int REC_W  = REC_VAL_BIT_WIDTH,
  parameter int RATE_W = RATE_BIT_WIDTH
);
  logic                     start_signal;
  logic [N_CH-1:0]          mode_angle;
  logic [REC_W-1:0]         throttle_target;
  logic [N_CH*REC_W-1:0]    targets;
  logic [N_CH*RATE_W-1:0]   actuals;
  logic [RATE_W-1:0]        throttle_rate_out;
  logic [N_CH*RATE_W-1:0]   rate_out;
  logic [N_CH*RATE_W-1:0]   angle_error;
  logic [N_CH-1:0]          sat_flags;
  logic                     active_signal;
  logic                     complete_signal;

  modport master (
    output start_signal, mode_angle, throttle_target, targets, actuals,
    input  throttle_rate_out, rate_out, angle_error, sat_flags, active_signal, complete_signal
  );

  modport slave (
    input  start_signal, mode_angle, throttle_target, targets, actuals,
    output throttle_rate_out, rate_out, angle_error, sat_flags, active_signal, complete_signal
  );
endinterface

// File: rtl/angle_setpoint_mapper_sat_clamp.sv
// Combinational signed clamp to [LIM_LO, LIM_HI] with narrowing and a saturation flag.
module angle_setpoint_mapper_sat_clamp #(
  parameter int IN_W   = 19,
  parameter int OUT_W  = 16,
  parameter int LIM_HI = 1600,
  parameter int LIM_LO = -1600
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);
  localparam logic signed [IN_W-1:0]  HI_IN  = IN_W'(LIM_HI);
  localparam logic signed [IN_W-1:0]  LO_IN  = IN_W'(LIM_LO);
  localparam logic signed [OUT_W-1:0] HI_OUT = OUT_W'(LIM_HI);
  localparam logic signed [OUT_W-1:0] LO_OUT = OUT_W'(LIM_LO);

  always_comb begin
    sat  = 1'b0;
    dout = din[OUT_W-1:0];
    if (din > HI_IN) begin
      dout = HI_OUT;
      sat  = 1'b1;
    end else if (din < LO_IN) begin
      dout = LO_OUT;
      sat  = 1'b1;
    end
  end
endmodule

// File: rtl/angle_setpoint_mapper.sv
// Serial multi-channel stick-to-rate mapper: latch, one channel per CALC cycle, atomic commit in DONE.
//   state | meaning
//   IDLE  | waiting for a start edge
//   LATCH | capture inputs, compute throttle
//   CALC  | process channel ch_idx into shadow registers
//   DONE  | results committed, complete pulse
module angle_setpoint_mapper
  import angle_setpoint_mapper_pkg::*;
#(
  parameter int              N_CH       = N_CH_DEF,
  parameter int              REC_W      = REC_VAL_BIT_WIDTH,
  parameter int              RATE_W     = RATE_BIT_WIDTH,
  parameter int              CENTER     = CENTER_31P25,
  parameter logic [N_CH-1:0] ACT_INVERT = N_CH'(3'b100),
  parameter int              DEADBAND   = DEADBAND_0P5,
  parameter int              GAIN_SHIFT = 0,
  parameter int              LIMIT      = LIMIT_100,
  parameter int              THR_MAX    = THR_250
) (
  input logic                   us_clk,
  input logic                   resetn,
  angle_setpoint_mapper_if.slave bus
);
  localparam int IW   = RATE_W + 3;
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic signed [IW-1:0] CENTER_S = IW'(CENTER);
  localparam logic signed [IW-1:0] DB_S     = IW'(DEADBAND);
  localparam logic [RATE_W-1:0]    THR_LIM  = RATE_W'(THR_MAX);

  state_t                 state_q, state_d;
  logic [CH_W-1:0]        ch_idx_q, ch_idx_d;
  logic                   pending_q, pending_d, start_q;
  logic [REC_W-1:0]       lat_thr_q, lat_thr_d;
  logic [N_CH*REC_W-1:0]  lat_tgt_q, lat_tgt_d;
  logic [N_CH*RATE_W-1:0] lat_act_q, lat_act_d;
  logic [N_CH-1:0]        lat_mode_q, lat_mode_d;
  logic [N_CH*RATE_W-1:0] rate_sh_q, rate_sh_d, err_sh_q, err_sh_d;
  logic [N_CH-1:0]        sat_sh_q, sat_sh_d;
  logic [RATE_W-1:0]      thr_sh_q, thr_sh_d;
  logic [N_CH*RATE_W-1:0] rate_out_q, rate_out_d, angle_err_q, angle_err_d;
  logic [N_CH-1:0]        sat_flags_q, sat_flags_d;
  logic [RATE_W-1:0]      thr_out_q, thr_out_d;
  logic                   active_q, active_d, complete_q, complete_d;
  logic                   start_rise;

  logic [REC_W-1:0]         rec_sel;
  logic signed [RATE_W-1:0] act_sel;
  logic signed [IW-1:0]     mapped, act_ext, err_raw, abs_err, err_db, scaled;
  logic signed [RATE_W-1:0] rate_ch, err_ch;
  logic                     rate_sat, err_sat;
  logic [RATE_W-1:0]        thr_raw, thr_clamped;

  assign start_rise = bus.start_signal & ~start_q;

  // Shared per-channel datapath, steered by ch_idx.
  always_comb begin
    rec_sel = lat_tgt_q[ch_idx_q*REC_W +: REC_W];
    act_sel = lat_act_q[ch_idx_q*RATE_W +: RATE_W];
    mapped  = $signed({{(IW-REC_W-2){1'b0}}, rec_sel, 2'b00}) - CENTER_S;
    act_ext = {{(IW-RATE_W){act_sel[RATE_W-1]}}, act_sel};
    err_raw = mapped;
    if (lat_mode_q[ch_idx_q])
      err_raw = ACT_INVERT[ch_idx_q] ? (mapped + act_ext) : (mapped - act_ext);
    abs_err = err_raw[IW-1] ? -err_raw : err_raw;
    err_db  = (abs_err <= DB_S) ? '0 : err_raw;
    scaled  = err_db <<< GAIN_SHIFT;
  end

  angle_setpoint_mapper_sat_clamp #(
    .IN_W(IW), .OUT_W(RATE_W), .LIM_HI(LIMIT), .LIM_LO(-LIMIT)
  ) u_rate_clamp (.din(scaled), .dout(rate_ch), .sat(rate_sat));

  angle_setpoint_mapper_sat_clamp #(
    .IN_W(IW), .OUT_W(RATE_W), .LIM_HI((2**(RATE_W-1))-1), .LIM_LO(-(2**(RATE_W-1)))
  ) u_err_clamp (.din(err_db), .dout(err_ch), .sat(err_sat));

  assign thr_raw     = {{(RATE_W-REC_W-4){1'b0}}, bus.throttle_target, 4'b0000};
  assign thr_clamped = (thr_raw > THR_LIM) ? THR_LIM : thr_raw;

  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    pending_d   = pending_q;
    lat_thr_d   = lat_thr_q;
    lat_tgt_d   = lat_tgt_q;
    lat_act_d   = lat_act_q;
    lat_mode_d  = lat_mode_q;
    rate_sh_d   = rate_sh_q;
    err_sh_d    = err_sh_q;
    sat_sh_d    = sat_sh_q;
    thr_sh_d    = thr_sh_q;
    rate_out_d  = rate_out_q;
    angle_err_d = angle_err_q;
    sat_flags_d = sat_flags_q;
    thr_out_d   = thr_out_q;
    case (state_q)
      ST_IDLE: if (start_rise) state_d = ST_LATCH;
      ST_LATCH: begin
        lat_thr_d  = bus.throttle_target;
        lat_tgt_d  = bus.targets;
        lat_act_d  = bus.actuals;
        lat_mode_d = bus.mode_angle;
        thr_sh_d   = thr_clamped;
        ch_idx_d   = '0;
        if (start_rise) pending_d = 1'b1;
        state_d    = ST_CALC;
      end
      ST_CALC: begin
        rate_sh_d[ch_idx_q*RATE_W +: RATE_W] = rate_ch;
        err_sh_d[ch_idx_q*RATE_W +: RATE_W]  = err_ch;
        sat_sh_d[ch_idx_q]                   = rate_sat | err_sat;
        ch_idx_d = ch_idx_q + 1'b1;
        if (start_rise) pending_d = 1'b1;
        // Commit uses the _d shadows so the last channel lands in the same edge.
        if (ch_idx_q == CH_W'(N_CH-1)) begin
          state_d     = ST_DONE;
          rate_out_d  = rate_sh_d;
          angle_err_d = err_sh_d;
          sat_flags_d = sat_sh_d;
          thr_out_d   = thr_sh_q;
        end
      end
      ST_DONE: begin
        if (pending_q | start_rise) begin
          state_d   = ST_LATCH;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    active_d   = (state_d == ST_LATCH) || (state_d == ST_CALC);
    complete_d = (state_d == ST_DONE);
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ch_idx_q    <= '0;
      pending_q   <= 1'b0;
      start_q     <= 1'b0;
      lat_thr_q   <= '0;
      lat_tgt_q   <= '0;
      lat_act_q   <= '0;
      lat_mode_q  <= '0;
      rate_sh_q   <= '0;
      err_sh_q    <= '0;
      sat_sh_q    <= '0;
      thr_sh_q    <= '0;
      rate_out_q  <= '0;
      angle_err_q <= '0;
      sat_flags_q <= '0;
      thr_out_q   <= '0;
      active_q    <= 1'b0;
      complete_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= ch_idx_d;
      pending_q   <= pending_d;
      start_q     <= bus.start_signal;
      lat_thr_q   <= lat_thr_d;
      lat_tgt_q   <= lat_tgt_d;
      lat_act_q   <= lat_act_d;
      lat_mode_q  <= lat_mode_d;
      rate_sh_q   <= rate_sh_d;
      err_sh_q    <= err_sh_d;
      sat_sh_q    <= sat_sh_d;
      thr_sh_q    <= thr_sh_d;
      rate_out_q  <= rate_out_d;
      angle_err_q <= angle_err_d;
      sat_flags_q <= sat_flags_d;
      thr_out_q   <= thr_out_d;
      active_q    <= active_d;
      complete_q  <= complete_d;
    end
  end

  assign bus.rate_out          = rate_out_q;
  assign bus.angle_error       = angle_err_q;
  assign bus.sat_flags         = sat_flags_q;
  assign bus.throttle_rate_out = thr_out_q;
  assign bus.active_signal     = active_q;
  assign bus.complete_signal   = complete_q;
endmodule

// File: tb/tb_angle_setpoint_mapper.sv
// Directed-vector bench for angle_setpoint_mapper, with a second THR_MAX=3200 instance.
module tb_angle_setpoint_mapper;
  import angle_setpoint_mapper_pkg::*;

  logic us_clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 us_clk = ~us_clk;

  angle_setpoint_mapper_if if0 ();
  angle_setpoint_mapper_if if1 ();

  assign if1.start_signal    = if0.start_signal;
  assign if1.mode_angle      = if0.mode_angle;
  assign if1.throttle_target = if0.throttle_target;
  assign if1.targets         = if0.targets;
  assign if1.actuals         = if0.actuals;

  angle_setpoint_mapper u_dut (.us_clk(us_clk), .resetn(resetn), .bus(if0.slave));
  angle_setpoint_mapper #(.THR_MAX(3200)) u_dut_thr (.us_clk(us_clk), .resetn(resetn), .bus(if1.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [7:0] rec, input logic [15:0] act);
    if0.targets[ch*8 +: 8]  = rec;
    if0.actuals[ch*16 +: 16] = act;
  endtask

  // One start pulse; checks active, output hold mid-CALC, latency and pulse width.
  task automatic run(input string tag);
    logic [47:0] prev;
    int lat;
    prev = if0.rate_out;
    lat = 0;
    if0.start_signal = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge us_clk); #1;
      if (i == 1) begin
        if0.start_signal = 1'b0;
        chk({tag, "_active"}, if0.active_signal, 1);
      end
      if (i == 3) chk({tag, "_hold"}, if0.rate_out, prev);
      if (if0.complete_signal) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 5);
    @(posedge us_clk); #1;
    chk({tag, "_pulse"}, if0.complete_signal, 0);
  endtask

  initial begin
    int completes, first, second;
    if0.start_signal    = 1'b0;
    if0.mode_angle      = 3'b000;
    if0.throttle_target = 8'd0;
    if0.targets         = '0;
    if0.actuals         = '0;
    repeat (3) @(posedge us_clk);
    #1;
    chk("rst_rate", if0.rate_out, 0);
    chk("rst_err", if0.angle_error, 0);
    chk("rst_sat", if0.sat_flags, 0);
    chk("rst_thr", if0.throttle_rate_out, 0);
    chk("rst_active", if0.active_signal, 0);
    chk("rst_complete", if0.complete_signal, 0);
    @(negedge us_clk) resetn = 1'b1;
    @(negedge us_clk);

    // Rate mode defaults
    set_ch(CH_YAW, 8'd200, 16'h0000);
    set_ch(CH_PITCH, 8'd125, 16'h0000);
    set_ch(CH_ROLL, 8'd50, 16'h0000);
    if0.throttle_target = 8'd250;
    run("t1");
    chk("t1_rate", if0.rate_out, 48'hFED4_0000_012C);
    chk("t1_sat", if0.sat_flags, 3'b000);
    chk("t1_thr", if0.throttle_rate_out, 16'd4000);
    chk("t1_thr3200", if1.throttle_rate_out, 16'd3200);

    // Angle mode, pitch subtracts, roll adds; yaw actual ignored
    if0.mode_angle = 3'b110;
    set_ch(CH_YAW, 8'd200, 16'h0050);
    set_ch(CH_PITCH, 8'd125, 16'h00A0);
    set_ch(CH_ROLL, 8'd125, 16'h00A0);
    if0.throttle_target = 8'd0;
    run("t2");
    chk("t2_rate", if0.rate_out, 48'h00A0_FF60_012C);
    chk("t2_err", if0.angle_error, 48'h00A0_FF60_012C);
    chk("t2_thr", if0.throttle_rate_out, 0);
    chk("t2_thr3200", if1.throttle_rate_out, 0);

    // Positive saturation on pitch, roll back to rate mode
    if0.mode_angle = 3'b010;
    set_ch(CH_PITCH, 8'd250, 16'hF9C0);
    set_ch(CH_ROLL, 8'd0, 16'h0123);
    if0.throttle_target = 8'd255;
    run("t3");
    chk("t3_rate", if0.rate_out, 48'hFE0C_0640_012C);
    chk("t3_err", if0.angle_error, 48'hFE0C_0834_012C);
    chk("t3_sat", if0.sat_flags, 3'b010);
    chk("t3_thr", if0.throttle_rate_out, 16'd4000);

    // Exactly at LIMIT: no saturation; roll add drives below -LIMIT
    if0.mode_angle = 3'b110;
    set_ch(CH_PITCH, 8'd125, 16'hF9C0);
    set_ch(CH_ROLL, 8'd0, 16'hFB50);
    run("t4");
    chk("t4_rate", if0.rate_out, 48'hF9C0_0640_012C);
    chk("t4_err", if0.angle_error, 48'hF95C_0640_012C);
    chk("t4_sat", if0.sat_flags, 3'b100);

    // Deadband edges on pitch
    if0.mode_angle = 3'b010;
    set_ch(CH_PITCH, 8'd125, 16'd5);
    run("db5");
    chk("db5_rate", if0.rate_out[31:16], 16'h0000);
    set_ch(CH_PITCH, 8'd125, 16'd8);
    run("db8");
    chk("db8_err", if0.angle_error[31:16], 16'h0000);
    set_ch(CH_PITCH, 8'd125, 16'd9);
    run("db9");
    chk("db9_rate", if0.rate_out[31:16], 16'hFFF7);
    chk("db9_err", if0.angle_error[31:16], 16'hFFF7);

    // Held-high start triggers once
    completes = 0;
    if0.start_signal = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge us_clk); #1;
      if (if0.complete_signal) completes++;
    end
    if0.start_signal = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge us_clk); #1;
      if (if0.complete_signal) completes++;
    end
    chk("held_count", completes, 1);

    // Second edge during CALC queues a rerun with re-latched inputs
    if0.mode_angle = 3'b000;
    set_ch(CH_YAW, 8'd200, 16'h0000);
    completes = 0; first = 0; second = 0;
    if0.start_signal = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge us_clk); #1;
      if (i == 1) if0.start_signal = 1'b0;
      if (i == 2) if0.start_signal = 1'b1;
      if (i == 3) begin
        if0.start_signal = 1'b0;
        set_ch(CH_YAW, 8'd250, 16'h0000);
      end
      if (if0.complete_signal) begin
        completes++;
        if (completes == 1) begin
          first = i;
          chk("b2b_yaw1", if0.rate_out[15:0], 16'd300);
        end else begin
          second = i;
        end
      end
    end
    chk("b2b_count", completes, 2);
    chk("b2b_first", first, 5);
    chk("b2b_second", second, 10);
    chk("b2b_yaw2", if0.rate_out[15:0], 16'd500);

    // Reset during CALC
    if0.throttle_target = 8'd100;
    completes = 0;
    if0.start_signal = 1'b1;
    @(posedge us_clk); #1;
    if0.start_signal = 1'b0;
    @(posedge us_clk); #1;
    resetn = 1'b0;
    #1;
    chk("rstc_rate", if0.rate_out, 0);
    chk("rstc_thr", if0.throttle_rate_out, 0);
    chk("rstc_active", if0.active_signal, 0);
    @(negedge us_clk);
    @(negedge us_clk) resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge us_clk); #1;
      if (if0.complete_signal) completes++;
    end
    chk("rstc_nocomplete", completes, 0);
    chk("rstc_idle", if0.active_signal, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
